int_to_fp_converter: RTL

// - Converts a 32-bit integer into the FPU operand format: [31]=sign, [30:25]=exp (6b, BIAS=31), [24:0]=mantissa (implicit leading 1).
// - Sits upstream of the FPU adder and produces its op_A_in/op_B_in words.
// - Normalizes iteratively, one left shift per cycle; valid/ready handshake on input and output.

---
 rtl/int_to_fp_converter_if.sv | 20 ++
 rtl/int_to_fp_converter.sv | 111 +++++++++++
 2 files changed

// File: rtl/int_to_fp_converter_if.sv
// rtl/int_to_fp_converter_if.sv - valid/ready handshake bundle for int_to_fp_converter
interface int_to_fp_converter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, status_out
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, status_out
  );
endinterface

// File: rtl/int_to_fp_converter.sv
// rtl/int_to_fp_converter.sv - 32-bit integer to FPU operand word, one normalizing shift per cycle
// Optional ROUND_NEAREST_EN selects round-to-nearest-even; default truncates toward zero.
module int_to_fp_converter #(
  parameter int SIGNED_IN = 1,
  parameter int BIAS      = 31
) (
  input logic                   clock,
  input logic                   reset,
  int_to_fp_converter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  // Exponent of 2^31, the value an unshifted mag with bit 31 set represents.
  localparam logic [6:0] EXP_INIT = 7'(BIAS + 31);

  state_t      state, next_state;
  logic [31:0] mag;
  logic [6:0]  exp_cnt;
  logic        sign_q;
  logic [31:0] data_q;
  logic [3:0]  status_q;

  logic        sign_in;
  logic [31:0] mag_in;
  logic [24:0] mant;
  logic        guard, sticky, inexact, round_up;
  logic [25:0] mant_sum;
  logic [6:0]  exp_r;
  logic [31:0] pack_word;
  logic [3:0]  pack_status;

  assign sign_in = (SIGNED_IN != 0) ? bus.data_in[31] : 1'b0;
  assign mag_in  = sign_in ? (~bus.data_in + 32'd1) : bus.data_in;

  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = NORM;
      end
      NORM: if (mag == 32'd0 || mag[31]) next_state = PACK;
      PACK: next_state = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mant    = mag[30:6];
    guard   = mag[5];
    sticky  = |mag[4:0];
    inexact = guard | sticky;
`ifdef ROUND_NEAREST_EN
    round_up = guard & (sticky | mant[0]);
`else
    round_up = 1'b0;
`endif
    // A carry out of the mantissa bumps the exponent; 63 means infinity.
    mant_sum    = {1'b0, mant} + {25'd0, round_up};
    exp_r       = exp_cnt + {6'd0, mant_sum[25]};
    pack_word   = {sign_q, exp_r[5:0], mant_sum[24:0]};
    pack_status = inexact ? 4'b1111 : 4'b0001;
    if (mag == 32'd0) begin
      pack_word   = 32'd0;
      pack_status = 4'b0001;
    end else if (exp_r >= 7'd63) begin
      pack_word   = {sign_q, 6'h3F, 25'd0};
      pack_status = 4'b0011;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      mag      <= 32'd0;
      exp_cnt  <= 7'd0;
      sign_q   <= 1'b0;
      data_q   <= 32'd0;
      status_q <= 4'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (bus.in_valid) begin
          sign_q  <= sign_in;
          mag     <= mag_in;
          exp_cnt <= EXP_INIT;
        end
        NORM: if (mag != 32'd0 && !mag[31]) begin
          mag     <= mag << 1;
          exp_cnt <= exp_cnt - 7'd1;
        end
        PACK: begin
          data_q   <= pack_word;
          status_q <= pack_status;
        end
        default: ;
      endcase
    end
  end

endmodule
